bpred_btb: RTL and testbench
============================

# bpred_btb

Parametrised branch-target buffer with 2-bit saturating direction counters for the pipelined processor's fetch stage. It replaces the fixed `pcpred = PC + INSTSIZE` predictor. The fetch stage looks up the current PC combinationally and receives a predicted next PC. The AGEN/EXEC stage writes back resolved branch and jump outcomes one cycle later, so taken control flow stops costing a flush after the first encounter.

## Interface
- `DBITS`, 32, address/data width
- `ENTRIES`, 64, table depth; power of two, ≥2
- `INSTSIZE`, 4, PC increment; instructions are word-aligned
- `IDXBITS`, log2(ENTRIES), index width (derived)
- `TAGBITS`, DBITS-IDXBITS-2, stored tag width (derived)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `pc_f`  in  DBITS  fetch-stage PC
- `pcpred_f`  out  DBITS  predicted next PC
- `hit_f`  out  1  valid tag match for `pc_f`
- `clear`  in  1  synchronous invalidate of all entries
- `upd_valid`  in  1  resolved control-flow instruction this cycle (non-nop only)
- `upd_pc`  in  DBITS  PC of resolved instruction
- `upd_isjump`  in  1  1 = JAL, 0 = conditional branch
- `upd_taken`  in  1  actual outcome
- `upd_target`  in  DBITS  actual taken target
- `upd_mispred`  in  1  EXEC-stage mispredict flag (`pcgood != pcpred`)
- `stat_upd`  out  32  update count (stats build only)
- `stat_mispred`  out  32  mispredict count (stats build only)

## Operation
- Index = `pc[IDXBITS+1:2]`. Tag = `pc[DBITS-1:IDXBITS+2]`. `pc[1:0]` is ignored.
- Entry fields: `valid`, `tag[TAGBITS]`, `target[DBITS]`, `isjump`, `ctr[2]`.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken when `ctr[1]`=1.
- Lookup:
  - `hit_f = valid && tag match`.
  - `pcpred_f = (hit_f && (isjump || ctr[1])) ? target : pc_f + INSTSIZE`, computed modulo 2^DBITS (wraps).
- Update, when `upd_valid`=1:
  - Hit, branch: counter increments if taken, decrements if not taken, saturating at 11 and 00. `target` is written only when taken.
  - Hit, jump: `ctr` ← 11, `target` ← `upd_target`.
  - Miss and taken: allocate, overwriting any alias (direct-mapped). Set `valid`=1, tag, target, `isjump`. `ctr` ← 10 for a branch, 11 for a jump.
  - Miss and not taken: no change.
- `clear`=1 clears every `valid` bit. When `clear` and `upd_valid` occur together, `clear` wins and no allocation happens.
- Only the `valid` bits and stats counters need reset. The `tag`, `target` and `ctr` storage has no reset and can map to RAM/MLAB.

## Timing
- Lookup has zero-cycle latency: purely combinational from `pc_f` and table state.
- An update is written on the `clk` edge where `upd_valid`=1 and is visible to lookup from the next cycle.
- A same-cycle lookup and update to the same index returns the pre-update contents. There is no bypass.
- Reset values:
  - All `valid` bits = 0, so `hit_f`=0 and `pcpred_f = pc_f + INSTSIZE`.
  - `stat_*` = 0.
- Reset asserted mid-operation takes effect immediately (asynchronous). Any update in flight that cycle is dropped.

## Configuration
- `BPRED_STATS_EN` defined:
  - `stat_upd` increments on every `upd_valid`.
  - `stat_mispred` increments on `upd_valid && upd_mispred`.
  - Both saturate at 32'hFFFFFFFF. Both are cleared by `reset` only, not by `clear`.
- `BPRED_STATS_EN` undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- `bpred_pkg` holds:
  - Counter encodings `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`.
  - The entry struct typedef.
  - Functions `bp_index(pc)` and `bp_tag(pc)`.
- One sub-module, `bpred_sat_ctr`: combinational 2-bit next-state from (`ctr`, `taken`, `isjump`, `alloc`). It is shared by the update path.

## Test plan
All cases use ENTRIES=64. PCs 0x100 and 0x200 both map to index 0, with tags 1 and 2.
- Reset released, `pc_f`=0x100 → `hit_f`=0, `pcpred_f`=0x104.
- Update {pc 0x100, branch, taken, target 0x180} → next cycle `pc_f`=0x100 gives `hit_f`=1, `pcpred_f`=0x180, `ctr`=10.
- Two not-taken updates on 0x100 → `ctr` 10→01→00; `pcpred_f`=0x104 with `hit_f`=1. A further not-taken update leaves `ctr` at 00.
- Update {pc 0x200, jump, target 0x300} → `pc_f`=0x200 gives 0x300; `pc_f`=0x100 misses and gives 0x104.
- Same-cycle checks:
  - Lookup of 0x100 while updating 0x100 returns the old prediction.
  - `clear` together with an allocate of 0x100 leaves `hit_f`=0 next cycle.
- `BPRED_STATS_EN`: 3 updates, 2 with `upd_mispred` → `stat_upd`=3, `stat_mispred`=2. Asserting `reset` mid-run zeroes both in the same cycle.

Source files
------------

// File: rtl/bpred_pkg.sv
// bpred_pkg: shared counter encodings, table entry layout and PC index/tag helpers for the BTB.
package bpred_pkg;
  localparam int BP_MAXW = 32;
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;
  // Widest view of one entry; narrower tags are zero-extended into it.
  typedef struct packed {
    logic               valid;
    logic [BP_MAXW-1:0] tag;
    logic [BP_MAXW-1:0] target;
    logic               isjump;
    logic [1:0]         ctr;
  } bp_entry_t;
  function automatic logic [BP_MAXW-1:0] bp_index(input logic [BP_MAXW-1:0] pc, input int idxbits);
    return (pc >> 2) & ~({BP_MAXW{1'b1}} << idxbits);
  endfunction
  function automatic logic [BP_MAXW-1:0] bp_tag(input logic [BP_MAXW-1:0] pc, input int idxbits);
    return pc >> (idxbits + 2);
  endfunction
endpackage

// File: rtl/bpred_btb_sat_ctr.sv
// bpred_sat_ctr: next value of a 2-bit saturating direction counter for a BTB update.
module bpred_sat_ctr
  import bpred_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  input  logic       isjump_i,
  input  logic       alloc_i,
  output logic [1:0] ctr_o
);
  always_comb
    ctr_o = isjump_i ? CTR_ST :
            alloc_i  ? CTR_WT :
            taken_i  ? ((ctr_i == CTR_ST)  ? CTR_ST  : ctr_i + 2'd1) :
                       ((ctr_i == CTR_SNT) ? CTR_SNT : ctr_i - 2'd1);
endmodule

// File: rtl/bpred_btb.sv
// bpred_btb: direct-mapped branch-target buffer with 2-bit direction counters (DBITS <= 32).
// Define BPRED_STATS_EN to build the saturating update/mispredict counters.
module bpred_btb
  import bpred_pkg::*;
#(
  parameter  int DBITS    = 32,
  parameter  int ENTRIES  = 64,
  parameter  int INSTSIZE = 4,
  localparam int IDXBITS  = $clog2(ENTRIES),
  localparam int TAGBITS  = DBITS - IDXBITS - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] pc_f,
  output logic [DBITS-1:0] pcpred_f,
  output logic             hit_f,
  input  logic             clear,
  input  logic             upd_valid,
  input  logic [DBITS-1:0] upd_pc,
  input  logic             upd_isjump,
  input  logic             upd_taken,
  input  logic [DBITS-1:0] upd_target,
  input  logic             upd_mispred,
  output logic [31:0]      stat_upd,
  output logic [31:0]      stat_mispred
);
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAGBITS-1:0] tag_q    [ENTRIES];
  logic [DBITS-1:0]   target_q [ENTRIES];
  logic               isjump_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [IDXBITS-1:0] f_idx, u_idx;
  logic [TAGBITS-1:0] f_tag, u_tag;
  logic               u_hit, u_we, alloc, tgt_we;
  logic [1:0]         ctr_n;
  bp_entry_t          f_ent;
  assign f_idx = IDXBITS'(bp_index(BP_MAXW'(pc_f), IDXBITS));
  assign f_tag = TAGBITS'(bp_tag(BP_MAXW'(pc_f), IDXBITS));
  assign u_idx = IDXBITS'(bp_index(BP_MAXW'(upd_pc), IDXBITS));
  assign u_tag = TAGBITS'(bp_tag(BP_MAXW'(upd_pc), IDXBITS));
  always_comb begin
    f_ent.valid  = valid_q[f_idx];
    f_ent.tag    = BP_MAXW'(tag_q[f_idx]);
    f_ent.target = BP_MAXW'(target_q[f_idx]);
    f_ent.isjump = isjump_q[f_idx];
    f_ent.ctr    = ctr_q[f_idx];
  end
  assign hit_f    = f_ent.valid && (f_ent.tag == BP_MAXW'(f_tag));
  assign pcpred_f = (hit_f && (f_ent.isjump || f_ent.ctr >= CTR_WT)) ? DBITS'(f_ent.target)
                                                                      : pc_f + DBITS'(INSTSIZE);
  // A resolved instruction touches the table only on a hit or a taken miss; clear suppresses it.
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_we   = upd_valid && !clear && (u_hit || upd_taken);
  assign alloc  = u_we && !u_hit;
  assign tgt_we = u_we && (upd_taken || upd_isjump);
  bpred_sat_ctr u_ctr (
    .ctr_i   (ctr_q[u_idx]),
    .taken_i (upd_taken),
    .isjump_i(upd_isjump),
    .alloc_i (alloc),
    .ctr_o   (ctr_n)
  );
  always_comb begin
    valid_d = valid_q;
    if (clear) valid_d = '0;
    else if (alloc) valid_d[u_idx] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) valid_q <= '0;
    else valid_q <= valid_d;
  always_ff @(posedge clk) begin
    if (u_we) begin
      tag_q[u_idx] <= u_tag;
      ctr_q[u_idx] <= ctr_n;
    end
    if (alloc) isjump_q[u_idx] <= upd_isjump;
    if (tgt_we) target_q[u_idx] <= upd_target;
  end
`ifdef BPRED_STATS_EN
  logic [31:0] stat_upd_q, stat_mispred_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_upd_q     <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (upd_valid && !(&stat_upd_q)) stat_upd_q <= stat_upd_q + 32'd1;
      if (upd_valid && upd_mispred && !(&stat_mispred_q)) stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  assign stat_upd     = stat_upd_q;
  assign stat_mispred = stat_mispred_q;
`else
  logic unused_mispred;
  assign unused_mispred = upd_mispred;
  assign stat_upd       = '0;
  assign stat_mispred   = '0;
`endif
endmodule

// File: tb/tb_bpred_btb.sv
// tb_bpred_btb: randomized scoreboard bench for bpred_btb against an array-based table model.
module tb_bpred_btb;
  logic        clk = 0, reset = 1, clear = 0;
  logic [31:0] pc_f = 0, pcpred_f, upd_pc = 0, upd_target = 0, stat_upd, stat_mispred;
  logic        hit_f, upd_valid = 0, upd_isjump = 0, upd_taken = 0, upd_mispred = 0;
  int          checks = 0, errors = 0;
  typedef struct {
    string       nm;
    logic        h;
    logic [31:0] p, su, sm;
  } exp_t;
  exp_t        q[$];
  bit          mv[64];
  logic [23:0] mt[64];
  logic [31:0] mtg[64];
  bit          mj[64];
  int          mc[64];
  longint      su = 0, sm = 0;

  bpred_btb dut (
    .clk(clk), .reset(reset), .pc_f(pc_f), .pcpred_f(pcpred_f), .hit_f(hit_f), .clear(clear),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_isjump(upd_isjump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .stat_upd(stat_upd), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".hit"}, {31'd0, hit_f}, {31'd0, e.h});
      chk({e.nm, ".pcpred"}, pcpred_f, e.p);
      chk({e.nm, ".stat_upd"}, stat_upd, e.su);
      chk({e.nm, ".stat_mispred"}, stat_mispred, e.sm);
    end

  task automatic model_lookup(input logic [31:0] pc, output logic h, output logic [31:0] p);
    int i;
    i = int'(pc[7:2]);
    h = mv[i] && mt[i] == pc[31:8];
    p = (h && (mj[i] || mc[i] >= 2)) ? mtg[i] : pc + 32'd4;
  endtask

  task automatic model_update();
    int  i;
    bit  h;
    i = int'(upd_pc[7:2]);
    h = mv[i] && mt[i] == upd_pc[31:8];
    if (upd_valid) begin
      if (su < 64'hFFFFFFFF) su++;
      if (upd_mispred && sm < 64'hFFFFFFFF) sm++;
    end
    if (clear) begin
      for (int k = 0; k < 64; k++) mv[k] = 0;
    end else if (upd_valid && h) begin
      if (upd_isjump) begin
        mc[i] = 3;
        mtg[i] = upd_target;
      end else if (upd_taken) begin
        mc[i] = (mc[i] == 3) ? 3 : mc[i] + 1;
        mtg[i] = upd_target;
      end else mc[i] = (mc[i] == 0) ? 0 : mc[i] - 1;
    end else if (upd_valid && upd_taken) begin
      mv[i] = 1;
      mt[i] = upd_pc[31:8];
      mtg[i] = upd_target;
      mj[i] = upd_isjump;
      mc[i] = upd_isjump ? 3 : 2;
    end
  endtask

  task automatic cyc(string nm, logic [31:0] pc, bit uv = 0, logic [31:0] upc = 0, bit uj = 0,
                     bit ut = 0, logic [31:0] utg = 0, bit um = 0, bit clr = 0, bit rst = 0);
    exp_t e;
    pc_f = pc; upd_valid = uv; upd_pc = upc; upd_isjump = uj; upd_taken = ut;
    upd_target = utg; upd_mispred = um; clear = clr; reset = rst;
    if (rst) begin
      for (int k = 0; k < 64; k++) mv[k] = 0;
      su = 0;
      sm = 0;
    end
    e.nm = nm;
    model_lookup(pc, e.h, e.p);
`ifdef BPRED_STATS_EN
    e.su = su[31:0];
    e.sm = sm[31:0];
`else
    e.su = 0;
    e.sm = 0;
`endif
    q.push_back(e);
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] x;
    x = $urandom;
    x[7:5] = 3'd0;
    if ($urandom_range(0, 9) < 8) x[31:8] = 24'($urandom_range(0, 3));
    return x;
  endfunction

  initial begin
    @(posedge clk); #1;
    cyc("in_reset", 32'h100, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("reset_lookup", 32'h100);
    cyc("alloc_same_cycle", 32'h100, 1, 32'h100, 0, 1, 32'h180, 1);
    cyc("hit_taken", 32'h100);
    cyc("nt1", 32'h100, 1, 32'h100, 0, 0, 0, 1);
    cyc("nt2", 32'h100, 1, 32'h100, 0, 0, 0, 0);
    cyc("nt3_sat", 32'h100, 1, 32'h100, 0, 0, 0, 0);
    cyc("ctr_floor", 32'h100, 1, 32'h100, 0, 1, 32'h1c0, 0);
    cyc("weak_nt", 32'h100);
    cyc("jump_alloc", 32'h200, 1, 32'h200, 1, 1, 32'h300, 1);
    cyc("jump_hit", 32'h200);
    cyc("alias_miss", 32'h100);
    cyc("clear_alloc", 32'h200, 1, 32'h100, 0, 1, 32'h180, 0, 1);
    cyc("after_clear_100", 32'h100);
    cyc("after_clear_200", 32'h200);
    cyc("wrap", 32'hFFFF_FFFC);
    cyc("wrap_alloc", 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 1, 32'h40, 0);
    cyc("wrap_hit", 32'hFFFF_FFFD);
    cyc("st_upd_a", 32'h104, 1, 32'h104, 0, 0, 0, 1);
    cyc("st_upd_b", 32'h104, 1, 32'h108, 0, 1, 32'h10, 1);
    cyc("st_upd_c", 32'h108);
    cyc("mid_reset", 32'h108, 1, 32'h108, 0, 1, 32'h20, 1, 0, 1);
    cyc("post_reset", 32'h108);
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] p, u;
      p = rpc();
      u = ($urandom_range(0, 3) == 0) ? p : rpc();
      cyc("rand", p, $urandom_range(0, 9) < 6, u, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
          $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end
    reset = 0;
    upd_valid = 0;
    clear = 0;
    for (int n = 0; n < 4 && q.size() > 0; n++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expectations never compared", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
